load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid (input, 1) and req_ready (output, 1): request handshake.
REQ-005 SHALL have ports req_we (input, 1), funct3 (input, 3), addr (input, ADDR_WIDTH) and wdata (input, 32): store flag, RV32I width code, byte address, store data.
REQ-006 SHALL have ports rsp_valid (output, 1) and rdata (output, 32): one-cycle completion pulse and load result.
REQ-007 SHALL have ports mem_we (output, 1), mem_a (output, ADDR_WIDTH), mem_wd (output, 32) and mem_rd (input, 32): word port to data memory, which reads synchronously with 1-cycle latency and does not read during a write cycle.
REQ-008 SHALL have port fault (output, 1): misalignment pulse, present only when MISALIGN_TRAP_EN is defined.

Function
REQ-009 SHALL use FSM states IDLE, RD_REQ, RD_DATA, MERGE and WR; req_ready SHALL be 1 only in IDLE.
REQ-010 SHALL capture addr, wdata, funct3 and req_we in cycle N when req_valid and req_ready are both 1.
REQ-011 SHALL drive mem_a as the captured addr with bits [1:0] forced to 0.
REQ-012 Loads (LB 000, LH 001, LW 010, LBU 100, LHU 101): RD_REQ in N+1 with mem_we=0, then RD_DATA in N+2; rsp_valid=1 and rdata updated in N+2; return to IDLE.
REQ-013 Load extraction: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-014 SW: WR in N+1 with mem_we=1 and mem_wd=wdata; rsp_valid=1 in N+1; no read issued.
REQ-015 SB/SH read-modify-write: RD_REQ in N+1, MERGE in N+2 (merge wdata[7:0]/[15:0] into the mem_rd lane and register the word), WR in N+3 with mem_we=1; rsp_valid in N+3.
REQ-016 mem_we SHALL be 1 only in WR; mem_wd SHALL be 0 outside WR.
REQ-017 rdata SHALL hold its value until the next load completes; stores SHALL not change it.
REQ-018 Undefined funct3 (loads 011/110/111; stores >010): no memory access; rsp_valid in N+1; rdata unchanged.
REQ-019 rsp_valid SHALL be a one-cycle pulse without backpressure; the next request SHALL be accepted no earlier than the cycle after rsp_valid.

Reset
REQ-020 rst_n low SHALL immediately force IDLE, req_ready=1, rsp_valid=0, mem_we=0, mem_a=0, mem_wd=0, rdata=0 and fault=0.
REQ-021 Reset during any non-IDLE state SHALL drop the pending operation: no write and no rsp_valid after release.

Configuration
REQ-022 Macro MISALIGN_TRAP_EN: when defined, LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 SHALL perform no memory access and SHALL pulse fault and rsp_valid in N+1, leaving rdata unchanged.
REQ-023 When MISALIGN_TRAP_EN is undefined, the fault port SHALL be absent; halfword accesses SHALL ignore addr[0] and word accesses SHALL ignore addr[1:0].

Structure
REQ-024 Package lsu_pkg SHALL hold the funct3 width-code enum and the FSM state typedef.
REQ-025 Sub-module load_align SHALL hold the combinational lane select and sign/zero extension; the merge logic stays in load_store_unit.

Verification (memory model: 1-cycle synchronous read, no read on a write cycle; word at 0x4 preloaded to 0x881122F0)
REQ-026 LB 0x4 -> rdata 0xFFFFFFF0 with rsp_valid in N+2; LBU 0x7 -> 0x00000088.
REQ-027 LH 0x6 -> 0xFFFF8811; LHU 0x4 -> 0x000022F0.
REQ-028 SB 0x5 with wdata 0x000000AB -> mem_we in N+3 with mem_wd 0x8811ABF0; a following LW 0x4 -> 0x8811ABF0.
REQ-029 SW 0x8 with wdata 0xDEADBEEF -> mem_we and rsp_valid in N+1, mem_a 0x8, no prior read cycle.
REQ-030 LW 0x2: with MISALIGN_TRAP_EN -> fault and rsp_valid in N+1, mem_we=0, rdata unchanged; without it -> word at 0x0 returned in N+2.
REQ-031 rst_n asserted while SH is in MERGE -> mem_we never asserts, no rsp_valid, req_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I width codes and FSM states.
// Optional misalignment trap is enabled with `define MISALIGN_TRAP_EN.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } width_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    MERGE,
    WR
  } state_e;

endpackage

// File: rtl/load_align.sv
// Load lane select plus sign/zero extension for LB/LH/LW/LBU/LHU.
// Pure combinational; undefined width codes return zero.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{off, 3'b000} +: 8];
    h    = off[1] ? word[31:16] : word[15:0];
    data = '0;
    unique case (1'b1)
      (funct3 == F3_B):  data = {{24{b[7]}}, b};
      (funct3 == F3_H):  data = {{16{h[15]}}, h};
      (funct3 == F3_W):  data = word;
      (funct3 == F3_BU): data = {24'h0, b};
      (funct3 == F3_HU): data = {16'h0, h};
      default:           data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit on a word-wide synchronous data memory port.
// `define MISALIGN_TRAP_EN adds the fault output and misaligned traps.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [31:0]           mem_wd,
`ifdef MISALIGN_TRAP_EN
  output logic                  fault,
`endif
  input  logic [31:0]           mem_rd
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wd_q;
  logic [2:0]            f3_q;
  logic                  we_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  undef;
  logic                  bad;
  logic [31:0]           ld_data;
  logic [31:0]           merged;

  assign accept = req_valid & req_ready;

  assign undef = req_we ? (funct3 > 3'b010)
                        : (funct3 == 3'b011) || (funct3[2:1] == 2'b11);

`ifdef MISALIGN_TRAP_EN
  logic mis;
  logic flt_q;

  assign mis = ((funct3[1:0] == 2'b01) & addr[0])
             | ((funct3 == F3_W) & (|addr[1:0]));
  assign bad   = undef | mis;
  assign fault = flt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flt_q <= 1'b0;
    else        flt_q <= accept & mis & ~undef;
  end
`else
  assign bad = undef;
`endif

  load_align u_align (
    .word   (mem_rd),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  // Sub-word store: drop the new lane into the word just read back.
  always_comb begin
    merged = mem_rd;
    if (f3_q[0]) begin
      if (addr_q[1]) merged[31:16] = wd_q[15:0];
      else           merged[15:0]  = wd_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !bad)
          state_d = (req_we && funct3 == F3_W) ? WR : RD_REQ;
      end
      RD_REQ:  state_d = we_q ? MERGE : RD_DATA;
      RD_DATA: state_d = IDLE;
      MERGE:   state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept & bad;
      if (accept) begin
        addr_q <= addr;
        wd_q   <= wdata;
        f3_q   <= funct3;
        we_q   <= req_we;
      end
      if (state_q == MERGE)   wd_q    <= merged;
      if (state_q == RD_DATA) rdata_q <= ld_data;
    end
  end

  // err_q holds off acceptance for the cycle the no-access response shows.
  assign req_ready = (state_q == IDLE) && !err_q;
  assign rsp_valid = (state_q == RD_DATA) || (state_q == WR) || err_q;
  assign rdata     = (state_q == RD_DATA) ? ld_data : rdata_q;
  assign mem_we    = (state_q == WR);
  assign mem_wd    = (state_q == WR) ? wd_q : 32'h0;
  assign mem_a     = {addr_q[ADDR_WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit; handles MISALIGN_TRAP_EN either way.
// Driver pushes expected responses/writes; negedge monitors pop and compare.
module tb_load_store_unit;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
`ifdef MISALIGN_TRAP_EN
  logic        fault;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
`ifdef MISALIGN_TRAP_EN
    .fault     (fault),
`endif
    .mem_rd    (mem_rd)
  );

  logic [31:0] mem [0:15];
  logic [31:0] rd_q;

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[5:2]] <= mem_wd;
    else        rd_q <= mem[mem_a[5:2]];
  end
  assign mem_rd = rd_q;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        flt;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    int          cyc;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  rsp_t re;
  wr_t  we_e;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_we) chk("mem_wd_idle", mem_wd, 32'h0);
      if (rsp_valid) begin
        if (rq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d, expected none", cyc);
        end else begin
          re = rq.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(re.cyc));
          chk("rdata", rdata, re.rdata);
`ifdef MISALIGN_TRAP_EN
          chk("fault", {31'h0, fault}, {31'h0, re.flt});
`endif
        end
      end
`ifdef MISALIGN_TRAP_EN
      if (!rsp_valid) chk("fault_idle", {31'h0, fault}, 32'h0);
`endif
      if (mem_we) begin
        if (wq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got mem_we at cycle %0d addr %h, expected none", cyc, mem_a);
        end else begin
          we_e = wq.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(we_e.cyc));
          chk("mem_a", mem_a, we_e.a);
          chk("mem_wd", mem_wd, we_e.wd);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int lat, input logic [31:0] er,
                       input logic ef, input bit wr, input int wlat,
                       input logic [31:0] wa, input logic [31:0] wwd,
                       input bit track);
    rsp_t r;
    wr_t  w;
    int   n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_ready_timeout: got 0 for 20 cycles, expected 1");
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    if (track) begin
      r.rdata = er;
      r.flt   = ef;
      r.cyc   = cyc + lat;
      rq.push_back(r);
      if (wr) begin
        w.a   = wa;
        w.wd  = wwd;
        w.cyc = cyc + wlat;
        wq.push_back(w);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0]    = 32'h13572468;
    mem[1]    = 32'h881122F0;
    rd_q      = 32'h0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 3'b000, 32'h4, 32'h0, 2, 32'hFFFFFFF0, 0, 0, 0, 0, 0, 1);
    issue(0, 3'b100, 32'h7, 32'h0, 2, 32'h00000088, 0, 0, 0, 0, 0, 1);
    issue(0, 3'b001, 32'h6, 32'h0, 2, 32'hFFFF8811, 0, 0, 0, 0, 0, 1);
    issue(0, 3'b101, 32'h4, 32'h0, 2, 32'h000022F0, 0, 0, 0, 0, 0, 1);
    issue(1, 3'b000, 32'h5, 32'h000000AB, 3, 32'h000022F0, 0,
          1, 3, 32'h4, 32'h8811ABF0, 1);
    issue(0, 3'b010, 32'h4, 32'h0, 2, 32'h8811ABF0, 0, 0, 0, 0, 0, 1);
    issue(1, 3'b010, 32'h8, 32'hDEADBEEF, 1, 32'h8811ABF0, 0,
          1, 1, 32'h8, 32'hDEADBEEF, 1);
    issue(0, 3'b010, 32'h8, 32'h0, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1);
    issue(1, 3'b001, 32'hA, 32'h1234CAFE, 3, 32'hDEADBEEF, 0,
          1, 3, 32'h8, 32'hCAFEBEEF, 1);
    issue(0, 3'b001, 32'hB, 32'h0, TRAP ? 1 : 2,
          TRAP ? 32'hDEADBEEF : 32'hFFFFCAFE, TRAP, 0, 0, 0, 0, 1);
    issue(0, 3'b010, 32'h2, 32'h0, TRAP ? 1 : 2,
          TRAP ? 32'hDEADBEEF : 32'h13572468, TRAP, 0, 0, 0, 0, 1);
    issue(0, 3'b011, 32'h4, 32'h0, 1,
          TRAP ? 32'hDEADBEEF : 32'h13572468, 0, 0, 0, 0, 0, 1);
    issue(1, 3'b011, 32'h4, 32'hFFFFFFFF, 1,
          TRAP ? 32'hDEADBEEF : 32'h13572468, 0, 0, 0, 0, 0, 1);
    issue(0, 3'b000, 32'h9, 32'h0, 2, 32'hFFFFFFBE, 0, 0, 0, 0, 0, 1);

    // SH to 0x4, then reset while it sits in MERGE
    issue(1, 3'b001, 32'h4, 32'h00005555, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("mrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mrst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("mrst_mem_wd", mem_wd, 32'h0);
    chk("mrst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
    issue(0, 3'b010, 32'h4, 32'h0, 2, 32'h8811ABF0, 0, 0, 0, 0, 0, 1);

    begin
      int n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (rq.size() != 0 || wq.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL drain: got %0d rsp and %0d writes pending, expected 0",
                 rq.size(), wq.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
